// File: rtl/rom_reader.sv
// Burst reader for a registered synchronous ROM.
// Issues credit-limited reads and streams words out through a 4-entry FIFO.
module rom_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  output logic              cs_n,
  output logic [ADDR_W-1:0] addm,
  input  logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_e;

  localparam int DEPTH = 4;
  localparam logic [ADDR_W:0] REM_ONE = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] addm_q, addm_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic cs_n_q, cs_n_d;
  logic last_q, last_d;
  logic rd_q, rd_d;
  logic rd_last_q, rd_last_d;
  logic done_q, done_d;
  logic [DATA_W:0] mem_q [DEPTH];
  logic [DATA_W:0] mem_d [DEPTH];
  logic [1:0] wp_q, wp_d;
  logic [1:0] rp_q, rp_d;
  logic [2:0] cnt_q, cnt_d;

  logic [2:0] inflight;
  logic       issue;
  logic       push;
  logic       pop;
  logic       head_last;

  always_comb begin
    inflight  = {2'b0, ~cs_n_q} + {2'b0, rd_q};
    // credit counts buffered plus in-flight words; same-cycle pops ignored
    issue     = (state_q == READ) && ((cnt_q + inflight) < 3'd4);
    push      = rd_q;
    pop       = (cnt_q != 3'd0) && m_ready;
    head_last = mem_q[rp_q][DATA_W];

    state_d   = state_q;
    addr_d    = addr_q;
    addm_d    = addm_q;
    rem_d     = rem_q;
    cs_n_d    = 1'b1;
    last_d    = 1'b0;
    rd_d      = ~cs_n_q;
    rd_last_d = last_q;
    done_d    = pop && head_last;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            addr_d  = start_addr;
            rem_d   = len;
            state_d = READ;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        if (issue) begin
          cs_n_d = 1'b0;
          addm_d = addr_q;
          addr_d = addr_q + ADDR_ONE;
          rem_d  = rem_q - REM_ONE;
          last_d = (rem_q == REM_ONE);
          if (rem_q == REM_ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    mem_d = mem_q;
    if (push) mem_d[wp_q] = {rd_last_q, dout};
    wp_d  = wp_q + {1'b0, push};
    rp_d  = rp_q + {1'b0, pop};
    cnt_d = cnt_q + {2'b0, push} - {2'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      addm_q    <= '0;
      rem_q     <= '0;
      cs_n_q    <= 1'b1;
      last_q    <= 1'b0;
      rd_q      <= 1'b0;
      rd_last_q <= 1'b0;
      done_q    <= 1'b0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      addm_q    <= addm_d;
      rem_q     <= rem_d;
      cs_n_q    <= cs_n_d;
      last_q    <= last_d;
      rd_q      <= rd_d;
      rd_last_q <= rd_last_d;
      done_q    <= done_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign cs_n    = cs_n_q;
  assign addm    = addm_q;
  assign m_valid = (cnt_q != 3'd0);
  assign m_data  = mem_q[rp_q][DATA_W-1:0];
  assign m_last  = m_valid && head_last;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_rom_reader.sv
// Self-checking bench for rom_reader against a word-list model of bursts.
// A registered ROM model with contents 0,1,2,4,8,16,32,64 drives dout.
module tb_rom_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [2:0] start_addr = '0;
  logic [3:0] len = '0;
  logic       cs_n;
  logic [2:0] addm;
  logic [7:0] dout = '0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic       m_last;
  logic       busy;
  logic       done;

  rom_reader #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .start_addr(start_addr), .len(len),
    .cs_n(cs_n), .addm(addm), .dout(dout),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [8] = '{8'd0, 8'd1, 8'd2, 8'd4,
                         8'd8, 8'd16, 8'd32, 8'd64};

  always @(posedge clk) if (!cs_n) dout <= rom[addm];

  int errs = 0;
  int checks = 0;

  logic [7:0] dat_q [$];
  logic       lst_q [$];
  logic [2:0] iss_q [$];
  int cs_lo_stall, stall_viol, busy_bad, busy_hi;
  int done_cnt, done_c, post_act, gaps, valid_cnt;
  int first_x, first_iss;

  // Expected burst: words rom[(sa+i) mod 8], addresses (sa+i) mod 8,
  // last flag only on word ln-1.  Returns number of discrepancies.
  function automatic int n_bad(input int sa, input int ln);
    int b;
    b = 0;
    if (dat_q.size() != ln) b++;
    if (iss_q.size() != ln) b++;
    foreach (dat_q[i]) begin
      if (i >= ln) b++;
      else if (dat_q[i] !== rom[3'(sa + i)]) b++;
      else if (lst_q[i] !== (i == ln - 1)) b++;
    end
    foreach (iss_q[i])
      if (i < ln && iss_q[i] !== 3'(sa + i)) b++;
    return b;
  endfunction

  // mode: 0 ready held, 1 ready low 10 cycles, 2 toggle, 3 random
  task automatic run_burst(input logic [2:0] sa, input logic [3:0] ln,
                           input int mode, input bit inj);
    bit         seen_done;
    bit         stall_prev;
    logic [7:0] prev_data;
    int         post;
    int         last_x;
    dat_q.delete(); lst_q.delete(); iss_q.delete();
    cs_lo_stall = 0; stall_viol = 0; busy_bad = 0; busy_hi = 0;
    done_cnt = 0; done_c = -1; post_act = 0; gaps = 0; valid_cnt = 0;
    first_x = -1; first_iss = -1;
    seen_done = 0; stall_prev = 0; prev_data = '0; post = 0;
    last_x = -1;
    m_ready = (mode != 1);
    @(posedge clk); #1;
    start = 1'b1; start_addr = sa; len = ln;
    @(posedge clk); #1;
    start = 1'b0;
    if (inj) begin
      start = 1'b1; start_addr = 3'd0; len = 4'd8;
    end
    for (int c = 0; c < 300 && post < 4; c++) begin
      @(negedge clk);
      if (seen_done) begin
        post++;
        if (!cs_n || m_valid) post_act++;
      end
      if (!cs_n) begin
        iss_q.push_back(addm);
        if (first_iss < 0) first_iss = c;
        if (!m_ready) cs_lo_stall++;
      end
      if (m_valid) valid_cnt++;
      if (busy) busy_hi++;
      if (stall_prev && (!m_valid || m_data !== prev_data))
        stall_viol++;
      if (m_valid && m_ready) begin
        dat_q.push_back(m_data);
        lst_q.push_back(m_last);
        if (last_x >= 0 && c != last_x + 1) gaps++;
        if (first_x < 0) first_x = c;
        last_x = c;
      end
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      if (done) begin
        done_cnt++;
        if (busy) busy_bad++;
        if (!seen_done) done_c = c;
        seen_done = 1;
      end else if (!seen_done && ln != 0 && !busy) begin
        busy_bad++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = (c >= 9);
        2: m_ready = ~m_ready;
        default: m_ready = 1'($urandom % 2);
      endcase
    end
    if (!seen_done)
      $display("FAIL timeout: no done for sa=%0d len=%0d", sa, ln);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #12;
    checks++;
    if ({cs_n, addm, m_valid, m_last, m_data, busy, done} !==
        {1'b1, 3'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL reset_vals: cs_n=%b addm=%0d v=%b l=%b d=%0d b=%b dn=%b",
               cs_n, addm, m_valid, m_last, m_data, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    int b;
    run_burst(3'd5, 4'd5, 0, 0);
    b = n_bad(5, 5);
    checks++;
    if (b !== 0) begin
      errs++; $display("FAIL wrap_stream: bad=%0d required 0", b);
    end
    checks++;
    if (gaps !== 0) begin
      errs++; $display("FAIL wrap_consec: gaps=%0d required 0", gaps);
    end
    checks++;
    if (first_x - first_iss !== 2) begin
      errs++;
      $display("FAIL wrap_latency: got %0d required 2", first_x - first_iss);
    end
    checks++;
    if (done_cnt !== 1 || done_c !== first_x + 5) begin
      errs++;
      $display("FAIL wrap_done: cnt=%0d at %0d required 1 at %0d",
               done_cnt, done_c, first_x + 5);
    end
    checks++;
    if (busy_bad !== 0 || post_act !== 0) begin
      errs++;
      $display("FAIL wrap_busy: busy_bad=%0d post=%0d required 0",
               busy_bad, post_act);
    end
  endtask

  task automatic test_stall();
    int b;
    run_burst(3'd0, 4'd8, 1, 0);
    checks++;
    if (cs_lo_stall !== 4) begin
      errs++;
      $display("FAIL stall_issues: got %0d required 4", cs_lo_stall);
    end
    b = n_bad(0, 8);
    checks++;
    if (b !== 0) begin
      errs++; $display("FAIL stall_stream: bad=%0d required 0", b);
    end
    checks++;
    if (done_cnt !== 1 || stall_viol !== 0) begin
      errs++;
      $display("FAIL stall_done: done=%0d viol=%0d required 1,0",
               done_cnt, stall_viol);
    end
  endtask

  task automatic test_len0();
    run_burst(3'd4, 4'd0, 0, 0);
    checks++;
    if (iss_q.size() !== 0) begin
      errs++; $display("FAIL len0_cs: issues=%0d required 0", iss_q.size());
    end
    checks++;
    if (valid_cnt !== 0) begin
      errs++; $display("FAIL len0_valid: got %0d required 0", valid_cnt);
    end
    checks++;
    if (done_cnt !== 1 || done_c !== 0) begin
      errs++;
      $display("FAIL len0_done: cnt=%0d at %0d required 1 at 0",
               done_cnt, done_c);
    end
    checks++;
    if (busy_hi !== 0) begin
      errs++; $display("FAIL len0_busy: got %0d required 0", busy_hi);
    end
  endtask

  task automatic test_ignore();
    int b;
    run_burst(3'd2, 4'd3, 0, 1);
    b = n_bad(2, 3);
    checks++;
    if (b !== 0) begin
      errs++; $display("FAIL ignore_stream: bad=%0d required 0", b);
    end
    checks++;
    if (post_act !== 0) begin
      errs++; $display("FAIL ignore_post: got %0d required 0", post_act);
    end
    checks++;
    if (done_cnt !== 1) begin
      errs++; $display("FAIL ignore_done: got %0d required 1", done_cnt);
    end
  endtask

  task automatic test_toggle();
    int b;
    run_burst(3'd0, 4'd8, 2, 0);
    b = n_bad(0, 8);
    checks++;
    if (b !== 0) begin
      errs++; $display("FAIL toggle_stream: bad=%0d required 0", b);
    end
    checks++;
    if (stall_viol !== 0) begin
      errs++; $display("FAIL toggle_hold: viol=%0d required 0", stall_viol);
    end
  endtask

  task automatic test_full();
    int b;
    int sa;
    sa = $urandom % 8;
    run_burst(3'(sa), 4'd8, 0, 0);
    b = n_bad(sa, 8);
    checks++;
    if (b !== 0) begin
      errs++; $display("FAIL full_sa%0d: bad=%0d required 0", sa, b);
    end
  endtask

  task automatic test_random();
    int sa, ln, b;
    for (int k = 0; k < 6; k++) begin
      sa = $urandom % 8;
      ln = $urandom_range(1, 8);
      run_burst(3'(sa), 4'(ln), 3, 0);
      b = n_bad(sa, ln);
      checks++;
      if (b !== 0 || stall_viol !== 0) begin
        errs++;
        $display("FAIL rand%0d_stream sa=%0d len=%0d: bad=%0d viol=%0d required 0",
                 k, sa, ln, b, stall_viol);
      end
      checks++;
      if (done_cnt !== 1 || busy_bad !== 0) begin
        errs++;
        $display("FAIL rand%0d_done: done=%0d busy_bad=%0d required 1,0",
                 k, done_cnt, busy_bad);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int b;
    bit hit;
    n = 0;
    hit = 0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; start_addr = 3'd0; len = 4'd8;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) n++;
      if (n == 3) hit = 1;
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (!hit || {cs_n, addm, m_valid, m_last, m_data, busy, done} !==
        {1'b1, 3'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL midreset_vals: hit=%b cs_n=%b addm=%0d v=%b d=%0d b=%b",
               hit, cs_n, addm, m_valid, m_data, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || m_valid !== 1'b0 || cs_n !== 1'b1) begin
      errs++;
      $display("FAIL midreset_quiet: done=%b v=%b cs_n=%b required 0,0,1",
               done, m_valid, cs_n);
    end
    run_burst(3'd3, 4'd2, 0, 0);
    b = n_bad(3, 2);
    checks++;
    if (b !== 0 || done_cnt !== 1) begin
      errs++;
      $display("FAIL midreset_next: bad=%0d done=%0d required 0,1",
               b, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_stall();
    test_len0();
    test_ignore();
    test_toggle();
    test_full();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
